// File: rtl/pulse_link_pkg.sv
// ----------------------------------------------------------------------------
// pulse_link_pkg
// Definitions shared by both ends of the stretched-pulse link, so that the
// transmitter (edge-to-pulse stretcher) and the receiver
// (pulse_stretch_decoder) agree on the nominal pulse width and on the
// receiver state encoding.
//   PULSE_W_DEF  : nominal HIGH width in clk cycles
//   WCNT_W       : width of the receiver's pulse-width counter
//   link_state_t : receiver FSM states (IDLE, HIGH, STUCK)
// ----------------------------------------------------------------------------
package pulse_link_pkg;

    localparam int PULSE_W_DEF = 3;
    localparam int WCNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        STUCK = 2'd2
    } link_state_t;

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit. Both flops clear to 0
// on reset.
// Ports:
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bit
//   q     : synchronised output (two clk cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pulse_stretch_decoder.sv
// ----------------------------------------------------------------------------
// pulse_stretch_decoder
// Receive side of the stretched-pulse link. Measures every HIGH pulse on
// dataIn and turns each pulse of acceptable width into a single-cycle event.
// Short pulses are flagged as glitches, overlong pulses as stuck lines, and
// accepted events are tallied in a saturating counter.
//
// Build option: define SYNC_EN to pass dataIn through a 2-flop synchroniser
// before measurement (adds 2 cycles to every output latency). Without it,
// dataIn must already be synchronous to clk.
//
// Parameters:
//   PULSE_W : nominal pulse width (2..15)
//   MAX_W   : widest accepted pulse (PULSE_W < MAX_W <= 15)
//   CNT_W   : event counter width
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   dataIn    : stretched pulse line
//   cnt_clr   : synchronous clear of evt_cnt (wins over a simultaneous evt)
//   evt       : strobe, pulse width PULSE_W..MAX_W received
//   merged    : strobe with evt when width > PULSE_W (retriggered pulse)
//   err_short : strobe, pulse width < PULSE_W
//   err_long  : strobe, pulse width has just exceeded MAX_W
//   busy      : a pulse is being measured (state HIGH or STUCK)
//   evt_cnt   : saturating count of evt strobes
// ----------------------------------------------------------------------------
module pulse_stretch_decoder
    import pulse_link_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int MAX_W   = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dataIn,
    input  logic             cnt_clr,
    output logic             evt,
    output logic             merged,
    output logic             err_short,
    output logic             err_long,
    output logic             busy,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [WCNT_W-1:0] PULSE_C = WCNT_W'(PULSE_W);
    localparam logic [WCNT_W-1:0] MAX_C   = WCNT_W'(MAX_W);

    link_state_t       state;
    logic [WCNT_W-1:0] wcnt;
    logic              d;

    // Width counter never wraps. In practice it tops out at MAX_W+1 because
    // the FSM leaves HIGH at that point; the all-ones guard only matters
    // when MAX_W is 15 and MAX_W+1 does not fit.
    function automatic logic [WCNT_W-1:0] wcnt_inc(input logic [WCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

`ifdef SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dataIn),
        .q     (d)
    );
`else
    assign d = dataIn;
`endif

    // Measurement FSM with registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= '0;
            evt       <= 1'b0;
            merged    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            evt       <= 1'b0;
            merged    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                IDLE: begin
                    // The rising sample itself counts as the first high cycle.
                    if (d) begin
                        state <= HIGH;
                        wcnt  <= WCNT_W'(1);
                    end
                end
                HIGH: begin
                    if (d) begin
                        wcnt <= wcnt_inc(wcnt);
                        // This is the (MAX_W+1)th high sample.
                        if (wcnt == MAX_C) begin
                            err_long <= 1'b1;
                            state    <= STUCK;
                        end
                    end else begin
                        // wcnt never exceeds MAX_W here, so anything not short
                        // is an accepted event.
                        if (wcnt < PULSE_C) begin
                            err_short <= 1'b1;
                        end else begin
                            evt    <= 1'b1;
                            merged <= (wcnt > PULSE_C);
                        end
                        state <= IDLE;
                        wcnt  <= '0;
                    end
                end
                STUCK: begin
                    // Already reported once; the eventual release is silent.
                    if (!d) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    // Event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt <= '0;
        end else if (evt) begin
            evt_cnt <= sat_inc(evt_cnt);
        end
    end

    assign busy = (state != IDLE);

endmodule
